shift_wb_stage: RTL

- Registered pipeline stage directly downstream of the combinational barrel shifter in the 16-bit execute path.
- Captures the shifter result together with the original operand, shift amount, direction and destination register.
- Computes the Z, N and C flags and an out-of-range indication.
- Presents the packet to writeback through a valid/ready handshake, with a 2-entry skid buffer so in_ready depends only on registered state.

---
 rtl/shift_wb_stage_pkg.sv | 24 ++
 rtl/shift_wb_stage_flags.sv | 47 ++++
 rtl/shift_wb_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/shift_wb_stage_pkg.sv
// Shared definitions for the shifter writeback stage: default widths,
// skid-buffer state encoding and the stored packet layout.
package shift_wb_stage_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int RD_W_DEF   = 3;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } st_t;

   // Packet layout at the default widths, MSB first: {result, rd, z, n, c, oor}.
   typedef struct packed {
      logic [DATA_W_DEF-1:0] result;
      logic [RD_W_DEF-1:0]   rd;
      logic                  z;
      logic                  n;
      logic                  c;
      logic                  oor;
   } pkt_t;

endpackage

// File: rtl/shift_wb_stage_flags.sv
// Combinational result and flag computation for the barrel shifter output:
// out-of-range squash, carry select, zero and negative flags.
module shift_flags
   import shift_wb_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_amt,
   input  logic              in_left,
   input  logic [DATA_W-1:0] in_shifted,
   output logic [DATA_W-1:0] out_result,
   output logic              out_z,
   output logic              out_n,
   output logic              out_c,
   output logic              out_oor
);

   localparam int LW = $clog2(DATA_W);

   logic [LW-1:0] w_amt_lo;
   logic [LW-1:0] w_lidx;
   logic [LW-1:0] w_ridx;
   logic          w_oor;

   // Result squash for out-of-range amounts and selection of the last bit shifted out
   always_comb begin
      w_oor    = (in_amt >= DATA_W'(DATA_W));
      w_amt_lo = in_amt[LW-1:0];
      // DATA_W - amt wraps correctly in LW bits for amt in 1..DATA_W-1
      w_lidx   = LW'(DATA_W) - w_amt_lo;
      w_ridx   = w_amt_lo - LW'(1);

      out_oor    = w_oor;
      out_result = w_oor ? '0 : in_shifted;
      if (w_oor || (in_amt == '0)) begin
         out_c = 1'b0;
      end else if (in_left) begin
         out_c = in_a[w_lidx];
      end else begin
         out_c = in_a[w_ridx];
      end
      out_z = (out_result == '0);
      out_n = out_result[DATA_W-1];
   end

endmodule

// File: rtl/shift_wb_stage.sv
// Registered writeback stage behind the barrel shifter. Two-slot skid buffer
// (MAIN drives the outputs, SKID absorbs one extra packet) so in_ready is a
// function of registered state only.
module shift_wb_stage
   import shift_wb_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_W   = RD_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_amt,
   input  logic              in_left,
   input  logic [DATA_W-1:0] in_shifted,
   input  logic [RD_W-1:0]   in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_z,
   output logic              out_n,
   output logic              out_c,
   output logic              out_oor
);

   localparam int PKT_W = DATA_W + RD_W + 4;

   st_t              r_state;
   st_t              w_next;
   logic [PKT_W-1:0] r_main;
   logic [PKT_W-1:0] r_skid;
   logic [PKT_W-1:0] w_pkt;
   logic [DATA_W-1:0] w_res;
   logic             w_z;
   logic             w_n;
   logic             w_c;
   logic             w_oor;
   logic             w_in_xfer;
   logic             w_out_xfer;

   shift_flags #(.DATA_W(DATA_W)) u_flags (
      .in_a       (in_a),
      .in_amt     (in_amt),
      .in_left    (in_left),
      .in_shifted (in_shifted),
      .out_result (w_res),
      .out_z      (w_z),
      .out_n      (w_n),
      .out_c      (w_c),
      .out_oor    (w_oor)
   );

   assign w_pkt = {w_res, in_rd, w_z, w_n, w_c, w_oor};

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: occupancy follows input and output transfers
   always_comb begin
      w_next = r_state;
      case (r_state)
         EMPTY: if (w_in_xfer) w_next = ONE;
         ONE: begin
            if (w_in_xfer && !w_out_xfer) begin
               w_next = TWO;
            end else if (!w_in_xfer && w_out_xfer) begin
               w_next = EMPTY;
            end
         end
         TWO:     if (w_out_xfer) w_next = ONE;
         default: w_next = EMPTY;
      endcase
   end

   // Handshake outputs; in_ready is held low while reset is asserted
   always_comb begin
      in_ready   = rst_n && (r_state != TWO);
      out_valid  = (r_state != EMPTY);
      w_in_xfer  = in_valid && in_ready;
      w_out_xfer = out_valid && out_ready;
   end

   // Slot storage: MAIN is the head of the FIFO, SKID the second entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         case (r_state)
            EMPTY: if (w_in_xfer) r_main <= w_pkt;
            ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  r_main <= w_pkt;
               end else if (w_in_xfer) begin
                  r_skid <= w_pkt;
               end
            end
            TWO:     if (w_out_xfer) r_main <= r_skid;
            default: ;
         endcase
      end
   end

   assign {out_result, out_rd, out_z, out_n, out_c, out_oor} = r_main;

endmodule
